vga_text_renderer: RTL and testbench

- Pixel-generation stage directly downstream of the VGA timing generator.
- Consumes the timing generator's column, line, visible, hsync and vsync. Fetches character and attribute words from an external synchronous text RAM, then fetches glyph rows from an external synchronous font ROM.
- Emits a 4-bit palette index per dot, with sync and visible re-aligned to the pixel pipeline.
- Adds a hardware text cursor and attribute-driven character blink, both timed by a frame counter.

---
 rtl/vga_text_renderer.sv | 146 ++++++++++++++
 tb/tb_vga_text_renderer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_renderer.sv
// Text-mode pixel pipeline: cell address -> text RAM -> font ROM -> palette index,
// with sync/visible delayed to match, plus a frame-timed cursor and character blink.
module vga_text_renderer #(
    parameter int TEXT_COLS       = 80,
    parameter int GLYPH_W         = 8,
    parameter int GLYPH_H         = 16,
    parameter int ADDR_W          = 12,
    parameter int COL_WIDTH       = 10,
    parameter int ROW_WIDTH       = 10,
    parameter int H_SYNC_POSITIVE = 0,
    parameter int V_SYNC_POSITIVE = 0,
    parameter int BLINK_FRAMES    = 16
) (
    input  logic                 dot_clk,
    input  logic                 reset,
    input  logic [COL_WIDTH-1:0] column,
    input  logic [ROW_WIDTH-1:0] line,
    input  logic                 visible,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    output logic [ADDR_W-1:0]    text_addr,
    input  logic [15:0]          text_data,
    output logic [11:0]          font_addr,
    input  logic [7:0]           font_data,
    input  logic [ADDR_W-1:0]    cursor_pos,
    input  logic                 cursor_enable,
    output logic [3:0]           pixel,
    output logic                 visible_out,
    output logic                 hsync_out,
    output logic                 vsync_out
);
    localparam int   CB       = $clog2(GLYPH_W);
    localparam int   RB       = $clog2(GLYPH_H);
    localparam int   CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic H_IDLE   = (H_SYNC_POSITIVE == 0);
    localparam logic V_ACTIVE = (V_SYNC_POSITIVE != 0);
    localparam logic V_IDLE   = ~V_ACTIVE;
    localparam logic [2:0] CTL_IDLE = {1'b0, H_IDLE, V_IDLE};

    // Stage 1: cell address and cursor match
    logic [ADDR_W-1:0] cell_addr;
    logic              cur_hit_next;

    assign cell_addr = ADDR_W'(line >> RB) * ADDR_W'(TEXT_COLS) + ADDR_W'(column >> CB);
    assign cur_hit_next = cursor_enable && (cell_addr == cursor_pos);

    logic [CB-1:0] s1_col_reg, s2_col_reg, s3_col_reg;
    logic [RB-1:0] s1_row_reg, s2_row_reg;
    logic          s1_cur_reg, s2_cur_reg, s3_cur_reg;
    logic [7:0]    s3_attr_reg;

    // {visible, hsync, vsync} delay line; entry 3 drives the outputs
    logic [2:0] ctl_reg [0:3];

    always_ff @(posedge dot_clk or posedge reset) begin
        if (reset) begin
            text_addr   <= '0;
            s1_col_reg  <= '0;
            s1_row_reg  <= '0;
            s1_cur_reg  <= 1'b0;
            s2_col_reg  <= '0;
            s2_row_reg  <= '0;
            s2_cur_reg  <= 1'b0;
            s3_col_reg  <= '0;
            s3_cur_reg  <= 1'b0;
            s3_attr_reg <= '0;
            for (int i = 0; i < 4; i++) ctl_reg[i] <= CTL_IDLE;
        end else begin
            text_addr   <= cell_addr;
            s1_col_reg  <= column[CB-1:0];
            s1_row_reg  <= line[RB-1:0];
            s1_cur_reg  <= cur_hit_next;
            s2_col_reg  <= s1_col_reg;
            s2_row_reg  <= s1_row_reg;
            s2_cur_reg  <= s1_cur_reg;
            s3_col_reg  <= s2_col_reg;
            s3_cur_reg  <= s2_cur_reg;
            s3_attr_reg <= text_data[15:8];
            ctl_reg[0]  <= {visible, hsync_in, vsync_in};
            for (int i = 1; i < 4; i++) ctl_reg[i] <= ctl_reg[i-1];
        end
    end

    // Stage 2: glyph row lookup straight from the returning text word
    assign font_addr = {text_data[7:0], s2_row_reg};

    // Frame counter: count inactive-to-active vsync transitions
    logic             vsync_prev_reg;
    logic [CNT_W-1:0] blink_cnt_reg;
    logic             blink_phase_reg;
    logic             frame_edge;

    assign frame_edge = (vsync_prev_reg == V_IDLE) && (vsync_in == V_ACTIVE);

    always_ff @(posedge dot_clk or posedge reset) begin
        if (reset) begin
            vsync_prev_reg  <= V_IDLE;
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else begin
            vsync_prev_reg <= vsync_in;
            if (frame_edge) begin
                if (blink_cnt_reg == CNT_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt_reg   <= '0;
                    blink_phase_reg <= ~blink_phase_reg;
                end else begin
                    blink_cnt_reg <= blink_cnt_reg + 1'b1;
                end
            end
        end
    end

    // Stage 3: dot select, blink and cursor colour rules
    logic       dot;
    logic [3:0] fg_base, bg_base, fg_eff, bg_eff, pixel_next;

    assign dot     = font_data[~s3_col_reg];
    assign fg_base = s3_attr_reg[3:0];
    assign bg_base = {1'b0, s3_attr_reg[6:4]};

    always_comb begin
        fg_eff = fg_base;
        bg_eff = bg_base;
        if (s3_attr_reg[7] && !blink_phase_reg) begin
            fg_eff = bg_base;
        end
        if (s3_cur_reg && blink_phase_reg) begin
            fg_eff = bg_base;
            bg_eff = fg_base;
        end
        pixel_next = ctl_reg[2][2] ? (dot ? fg_eff : bg_eff) : 4'd0;
    end

    always_ff @(posedge dot_clk or posedge reset) begin
        if (reset) begin
            pixel <= '0;
        end else begin
            pixel <= pixel_next;
        end
    end

    assign visible_out = ctl_reg[3][2];
    assign hsync_out   = ctl_reg[3][1];
    assign vsync_out   = ctl_reg[3][0];

endmodule

// File: tb/tb_vga_text_renderer.sv
// Directed bench for vga_text_renderer: synchronous RAM/ROM models, expected
// outputs queued per vector and compared exactly four cycles later.
module tb_vga_text_renderer;
    logic        dot_clk;
    logic        reset;
    logic [9:0]  column;
    logic [9:0]  line;
    logic        visible;
    logic        hsync_in;
    logic        vsync_in;
    logic [11:0] text_addr;
    logic [15:0] text_data = '0;
    logic [11:0] font_addr;
    logic [7:0]  font_data = '0;
    logic [11:0] cursor_pos;
    logic        cursor_enable;
    logic [3:0]  pixel;
    logic        visible_out;
    logic        hsync_out;
    logic        vsync_out;

    vga_text_renderer dut (
        .dot_clk       (dot_clk),
        .reset         (reset),
        .column        (column),
        .line          (line),
        .visible       (visible),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .text_addr     (text_addr),
        .text_data     (text_data),
        .font_addr     (font_addr),
        .font_data     (font_data),
        .cursor_pos    (cursor_pos),
        .cursor_enable (cursor_enable),
        .pixel         (pixel),
        .visible_out   (visible_out),
        .hsync_out     (hsync_out),
        .vsync_out     (vsync_out)
    );

    initial begin
        dot_clk = 1'b0;
        forever #5 dot_clk = ~dot_clk;
    end

    logic [15:0] text_mem [0:4095];
    logic [7:0]  font_mem [0:4095];

    always @(posedge dot_clk) begin
        text_data <= text_mem[text_addr];
        font_data <= font_mem[font_addr];
    end

    typedef struct packed {
        int         id;
        logic [3:0] pix;
        logic       vis;
        logic       hs;
        logic       vs;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   next_id     = 0;
    int   addr_pend   = -1;
    logic cur_en_want = 1'b0;

    logic [3:0] row0_exp  [8] = '{4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7};
    logic [3:0] row1_exp  [8] = '{4'd0, 4'd0, 4'd7, 4'd7, 4'd7, 4'd7, 4'd0, 4'd0};
    logic [3:0] cell2_exp [8] = '{4'hA, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'hA};
    logic [7:0] hs_pat = 8'b0110_1001;

    task automatic check(input string tag, input int vid, input logic [15:0] obs,
                         input logic [15:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s v%0d observed=%0h expected=%0h", tag, vid, obs, expv);
        end
    endtask

    // Checks the vector applied four steps ago, then drives a new one.
    task automatic step(input int c, input int l, input logic vis, input logic hs,
                        input logic vs, input logic [3:0] pix, input int addr);
        exp_t e;
        @(negedge dot_clk);
        if (addr_pend >= 0) check("text_addr", next_id - 1, 16'(text_addr), 16'(addr_pend));
        if (q.size() == 4) begin
            e = q.pop_front();
            check("pixel",       e.id, 16'(pixel),       16'(e.pix));
            check("visible_out", e.id, 16'(visible_out), 16'(e.vis));
            check("hsync_out",   e.id, 16'(hsync_out),   16'(e.hs));
            check("vsync_out",   e.id, 16'(vsync_out),   16'(e.vs));
        end
        column        = 10'(c);
        line          = 10'(l);
        visible       = vis;
        hsync_in      = hs;
        vsync_in      = vs;
        cursor_enable = cur_en_want;
        q.push_back('{next_id, pix, vis, hs, vs});
        addr_pend = addr;
        next_id++;
    endtask

    task automatic prefill_reset();
        q.delete();
        repeat (4) q.push_back('{-1, 4'd0, 1'b0, 1'b1, 1'b1});
        addr_pend = -1;
    endtask

    task automatic check_reset_now(input int vid);
        check("rst_pixel",   vid, 16'(pixel),       16'h0);
        check("rst_visible", vid, 16'(visible_out), 16'h0);
        check("rst_hsync",   vid, 16'(hsync_out),   16'h1);
        check("rst_vsync",   vid, 16'(vsync_out),   16'h1);
        check("rst_addr",    vid, 16'(text_addr),   16'h0);
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) begin
            text_mem[a] = 16'h0741;
            font_mem[a] = 8'h00;
        end
        font_mem[12'h410] = 8'h81;
        font_mem[12'h411] = 8'h3C;
        text_mem[1]       = 16'hB741;
        text_mem[2]       = 16'h1A41;

        reset = 1'b1; column = '0; line = '0; visible = 1'b0;
        hsync_in = 1'b1; vsync_in = 1'b1; cursor_pos = '0; cursor_enable = 1'b0;
        repeat (3) @(posedge dot_clk);
        #1 check_reset_now(-1);
        @(posedge dot_clk);
        #1 reset = 1'b0;
        prefill_reset();

        // glyph rows and colours
        for (int i = 0; i < 8; i++) step(i, 0, 1'b1, 1'b1, 1'b1, row0_exp[i], (i == 0) ? 0 : -1);
        for (int i = 0; i < 8; i++) step(i, 1, 1'b1, 1'b1, 1'b1, row1_exp[i], -1);
        for (int i = 0; i < 8; i++) step(16 + i, 0, 1'b1, 1'b1, 1'b1, cell2_exp[i], (i == 0) ? 2 : -1);

        // address corners
        step(639, 479, 1'b0, 1'b1, 1'b1, 4'd0, 2399);
        step(8, 16, 1'b0, 1'b1, 1'b1, 4'd0, 81);

        // blanking over a lit dot with hsync toggling
        for (int i = 0; i < 8; i++) step(0, 0, 1'b0, hs_pat[i], 1'b1, 4'd0, -1);

        // cursor enabled but blink phase 0: no swap
        cursor_pos  = 12'd81;
        cur_en_want = 1'b1;
        step(8, 16, 1'b1, 1'b1, 1'b1, 4'd7, -1);
        step(9, 16, 1'b1, 1'b1, 1'b1, 4'd0, -1);
        cur_en_want = 1'b0;

        // blink cell in phase 0 renders all background
        step(8, 0, 1'b1, 1'b1, 1'b1, 4'd3, -1);
        step(9, 0, 1'b1, 1'b1, 1'b1, 4'd3, -1);

        // fifteen frame edges, one of them with vsync held active
        for (int p = 0; p < 15; p++) begin
            step(0, 0, 1'b0, 1'b1, 1'b0, 4'd0, -1);
            if (p == 3) step(0, 0, 1'b0, 1'b1, 1'b0, 4'd0, -1);
            step(0, 0, 1'b0, 1'b1, 1'b1, 4'd0, -1);
        end
        step(8, 0, 1'b1, 1'b1, 1'b1, 4'd3, -1);
        step(15, 0, 1'b1, 1'b1, 1'b1, 4'd3, -1);
        repeat (3) step(0, 0, 1'b0, 1'b1, 1'b1, 4'd0, -1);

        // sixteenth edge: phase 1
        step(0, 0, 1'b0, 1'b1, 1'b0, 4'd0, -1);
        step(0, 0, 1'b0, 1'b1, 1'b1, 4'd0, -1);
        step(8, 0, 1'b1, 1'b1, 1'b1, 4'd7, -1);
        step(9, 0, 1'b1, 1'b1, 1'b1, 4'd3, -1);
        step(15, 0, 1'b1, 1'b1, 1'b1, 4'd7, -1);
        step(0, 0, 1'b1, 1'b1, 1'b1, 4'd7, -1);

        // cursor in phase 1
        cur_en_want = 1'b1;
        step(8, 16, 1'b1, 1'b1, 1'b1, 4'd0, -1);
        step(9, 16, 1'b1, 1'b1, 1'b1, 4'd7, -1);
        step(15, 16, 1'b1, 1'b1, 1'b1, 4'd0, -1);
        step(0, 16, 1'b1, 1'b1, 1'b1, 4'd7, -1);
        step(16, 16, 1'b1, 1'b1, 1'b1, 4'd7, -1);
        cur_en_want = 1'b0;
        step(8, 16, 1'b1, 1'b1, 1'b1, 4'd7, -1);
        step(9, 16, 1'b1, 1'b1, 1'b1, 4'd0, -1);

        // mid-line reset while lit dots and active hsync are in flight
        for (int i = 0; i < 5; i++) step(0, 0, 1'b1, 1'b0, 1'b1, 4'd7, -1);
        #2 reset = 1'b1;
        #1 check_reset_now(-2);
        @(posedge dot_clk);
        @(posedge dot_clk);
        #1 reset = 1'b0;
        prefill_reset();

        step(0, 0, 1'b1, 1'b1, 1'b1, 4'd7, 0);
        step(8, 0, 1'b1, 1'b1, 1'b1, 4'd3, 1);
        repeat (4) step(0, 0, 1'b0, 1'b1, 1'b1, 4'd0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
